// File: rtl/router_add_seq.sv
// rtl/router_add_seq.sv - program sequencer driving one router_add control interface
// A one-cycle FETCH state separates start from the first word so outputs are always registered state.
module router_add_seq #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int CW    = 15
) (
    input  logic          clk_in,
    input  logic          rstb,
    input  logic          cfg_wr_en,
    input  logic [AW-1:0] cfg_addr,
    input  logic [CW-1:0] cfg_data,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          add_sel,
    output logic          add_en,
    output logic          sum_en,
    output logic          ps_en,
    output logic          bypass_en,
    output logic          consec_add_en,
    output logic [1:0]    input_sel,
    output logic [2:0]    output_sel
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_mem [DEPTH];
    logic [CW-1:0] r_word;
    logic [AW-1:0] r_pc;
    logic [3:0]    r_cnt;
    logic          r_err;

    logic          w_run;
    logic          w_word_end;
    logic          w_last;
    logic          w_advance;
    logic          w_pc_wrap;
    logic [AW-1:0] w_pc_nxt;

    assign w_run      = (r_state == S_RUN);
    assign w_word_end = (r_cnt == r_word[3:0]);
    assign w_last     = r_word[14];
    assign w_advance  = w_run && !abort && w_word_end && !w_last;
    assign w_pc_wrap  = (r_pc == AW'(DEPTH - 1));
    assign w_pc_nxt   = w_pc_wrap ? '0 : r_pc + 1'b1;

    always_ff @(posedge clk_in or negedge rstb) begin
        if (!rstb) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // abort outranks both the word-end test and the last flag
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_FETCH;
            S_FETCH: w_next = abort ? S_IDLE : S_RUN;
            S_RUN: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_word_end && w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rstb) begin
        if (!rstb) begin
            r_word <= '0;
            r_pc   <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_word <= r_mem[0];
                    r_pc   <= '0;
                    r_cnt  <= '0;
                end
                S_RUN: begin
                    if (w_advance) begin
                        r_word <= r_mem[w_pc_nxt];
                        r_pc   <= w_pc_nxt;
                        r_cnt  <= '0;
                        if (w_pc_wrap) begin
                            r_err <= 1'b1;
                        end
                    end else if (!w_word_end) begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_pc  <= '0;
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Program store is not reset; the running program is frozen against writes
    always_ff @(posedge clk_in) begin
        if (cfg_wr_en && !w_run) begin
            r_mem[cfg_addr] <= cfg_data;
        end
    end

    assign busy          = w_run;
    assign add_sel       = w_run;
    assign done          = (r_state == S_DONE);
    assign err           = r_err;
    assign add_en        = w_run & r_word[4];
    assign sum_en        = w_run & r_word[5];
    assign ps_en         = w_run & r_word[6];
    assign bypass_en     = w_run & r_word[7];
    assign consec_add_en = w_run & r_word[8];
    assign input_sel     = w_run ? r_word[10:9]  : 2'b00;
    assign output_sel    = w_run ? r_word[13:11] : 3'b000;

endmodule

// File: tb/tb_router_add_seq.sv
// tb/tb_router_add_seq.sv - randomized bench for router_add_seq against a timeline model
module tb_router_add_seq;

    logic        clk_in = 1'b0;
    logic        rstb = 1'b0;
    logic        cfg_wr_en = 1'b0;
    logic [3:0]  cfg_addr = 4'd0;
    logic [14:0] cfg_data = 15'd0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy, done, err, add_sel, add_en, sum_en, ps_en, bypass_en, consec_add_en;
    logic [1:0]  input_sel;
    logic [2:0]  output_sel;

    router_add_seq #(.DEPTH(16), .AW(4), .CW(15)) dut (
        .clk_in(clk_in), .rstb(rstb), .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .start(start), .abort(abort), .busy(busy), .done(done),
        .err(err), .add_sel(add_sel), .add_en(add_en), .sum_en(sum_en), .ps_en(ps_en),
        .bypass_en(bypass_en), .consec_add_en(consec_add_en), .input_sel(input_sel),
        .output_sel(output_sel)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Output vector: {err, done, busy, add_sel, output_sel, input_sel, consec, bypass, ps, sum, add}
    logic [13:0] q[$];
    logic        err_m = 1'b0;
    logic [14:0] mem_m [16];

    function automatic logic [13:0] dut_vec();
        return {err, done, busy, add_sel, output_sel, input_sel,
                consec_add_en, bypass_en, ps_en, sum_en, add_en};
    endfunction

    function automatic logic [13:0] exp_vec();
        return (q.size() > 0) ? q[0] : {err_m, 13'd0};
    endfunction

    function automatic logic [14:0] mkw(input bit last, input int osel, input int isel,
                                        input bit cons, input bit byp, input bit ps,
                                        input bit sum, input bit add, input int rpt);
        return {last, 3'(osel), 2'(isel), cons, byp, ps, sum, add, 4'(rpt)};
    endfunction

    // Expand the whole run into one vector per cycle: a quiet start cycle, each word
    // rpt+1 times, then a single done cycle.
    task automatic build();
        int   pc = 0;
        logic e  = err_m;
        q.push_back({e, 13'd0});
        while (q.size() < 400) begin
            logic [14:0] w = mem_m[pc];
            for (int r = 0; r <= int'(w[3:0]); r++) begin
                q.push_back({e, 1'b0, 1'b1, 1'b1, w[13:4]});
            end
            if (w[14]) begin
                q.push_back({e, 1'b1, 12'd0});
                break;
            end
            pc++;
            if (pc == 16) begin
                pc = 0;
                e  = 1'b1;
            end
        end
    endtask

    task automatic model_step(input logic s, input logic a, input logic w,
                              input logic [3:0] ad, input logic [14:0] d);
        logic [13:0] cur = exp_vec();
        if (w && !cur[11]) mem_m[ad] = d;
        if (q.size() > 0) begin
            err_m = cur[13];
            void'(q.pop_front());
            if (a && !cur[12]) q.delete();
        end else if (s) begin
            build();
        end
    endtask

    task automatic cyc(input logic s, input logic a, input logic w,
                       input logic [3:0] ad, input logic [14:0] d);
        start = s; abort = a; cfg_wr_en = w; cfg_addr = ad; cfg_data = d;
        @(posedge clk_in);
        model_step(s, a, w, ad, d);
        @(negedge clk_in);
        chk("cycle", 32'(dut_vec()), 32'(exp_vec()));
        start = 1'b0; abort = 1'b0; cfg_wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 4'd0, 15'd0);
    endtask

    task automatic wr(input int ad, input logic [14:0] d);
        cyc(1'b0, 1'b0, 1'b1, 4'(ad), d);
    endtask

    task automatic run_out(input int lim);
        for (int i = 0; i < lim && q.size() > 0; i++) idle(1);
        if (q.size() != 0) chk("run_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk_in);
        @(negedge clk_in);
        chk("reset_state", 32'(dut_vec()), 32'd0);
        rstb = 1'b1;

        // single word held three cycles
        wr(0, mkw(1, 0, 1, 0, 0, 0, 0, 1, 2));
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 15'd0);
        run_out(20);
        idle(2);

        // three back-to-back words
        wr(0, mkw(0, 2, 0, 0, 0, 1, 0, 0, 0));
        wr(1, mkw(0, 0, 0, 1, 0, 0, 0, 1, 1));
        wr(2, mkw(1, 4, 0, 0, 0, 0, 1, 0, 0));
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 15'd0);
        run_out(20);

        // single-cycle program; write to entry 0 lands in the same cycle as start
        cyc(1'b1, 1'b1, 1'b1, 4'd0, mkw(1, 7, 3, 1, 1, 1, 1, 1, 0));
        run_out(10);

        // mid-run start and entry-3 rewrite are ignored; replay uses the original entry 3
        for (int i = 0; i < 5; i++) wr(i, mkw(i == 4, i, i % 4, 0, 1, 0, 1, 0, 1));
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 15'd0);
        idle(3);
        cyc(1'b1, 1'b0, 1'b1, 4'd3, mkw(1, 7, 3, 1, 1, 1, 1, 1, 9));
        run_out(30);
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 15'd0);
        run_out(30);

        // abort inside a long word, then a fresh run from entry 0
        wr(0, mkw(0, 1, 2, 0, 0, 0, 1, 1, 5));
        wr(1, mkw(1, 3, 1, 1, 0, 0, 0, 0, 0));
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 15'd0);
        idle(3);
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 15'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        idle(1);
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 15'd0);
        run_out(20);

        // overrun: no last bit anywhere
        for (int i = 0; i < 16; i++) wr(i, mkw(0, i % 8, i % 4, 0, 0, i % 2, 0, 1, 0));
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 15'd0);
        idle(22);
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 15'd0);
        idle(2);
        chk("err_sticky", 32'(err), 32'd1);

        // asynchronous reset between edges during a run
        wr(0, mkw(1, 5, 2, 0, 1, 0, 0, 0, 6));
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 15'd0);
        idle(3);
        #2 rstb = 1'b0;
        #1 chk("async_reset", 32'(dut_vec()), 32'd0);
        q.delete();
        err_m = 1'b0;
        @(negedge clk_in);
        rstb = 1'b1;
        idle(1);
        chk("reset_err", 32'(err), 32'd0);

        // randomized programs with stray start/abort/write traffic
        for (int it = 0; it < 25; it++) begin
            int len = 1 + $urandom_range(4);
            for (int i = 0; i < len; i++) begin
                logic [14:0] w = 15'($urandom) & 15'h3ff0;
                w[3:0] = 4'($urandom_range(3));
                w[14]  = (i == len - 1);
                wr(i, w);
            end
            cyc(1'b1, 1'($urandom_range(1)), 1'b0, 4'd0, 15'd0);
            for (int i = 0; i < 100 && q.size() > 0; i++) begin
                logic [13:0] cur = exp_vec();
                cyc(1'($urandom_range(5) == 0), 1'($urandom_range(19) == 0),
                    cur[11] && ($urandom_range(3) == 0), 4'($urandom_range(15)), 15'($urandom));
            end
            if (q.size() != 0) chk("rand_timeout", 32'(q.size()), 32'd0);
            cyc(1'b0, 1'($urandom_range(1)), 1'b0, 4'd0, 15'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
